// File: rtl/usb_uart_fifo_bridge_ep.sv
// usb_uart_fifo_bridge_ep
// Data-endpoint bridge between the USB full-speed protocol engine (one OUT
// and one IN endpoint slot) and a byte-wide valid/ready UART pipeline.
// Contents: OUT FIFO with request/get FSM, IN FIFO with packetiser FSM,
// idle-flush timer for short IN packets, and SOF-based host-presence
// tracking. IN bytes arriving while no host is present are accepted and
// dropped.
// Optional feature: define USB_UART_ZLP_EN to follow a MAX_PKT-length IN
// packet with a zero-length packet once the FIFO stays empty and the flush
// timer expires. When it is undefined, no ZLPs are sent.
module usb_uart_fifo_bridge_ep #(
  parameter int IN_DEPTH        = 64,
  parameter int OUT_DEPTH       = 64,
  parameter int MAX_PKT         = 32,
  parameter int FLUSH_CYCLES    = 48000,
  parameter int PRESENCE_CYCLES = 48000000
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  // OUT endpoint (host -> device)
  output logic       out_ep_req,
  input  logic       out_ep_grant,
  input  logic       out_ep_data_avail,
  input  logic       out_ep_setup,
  output logic       out_ep_data_get,
  input  logic [7:0] out_ep_data,
  output logic       out_ep_stall,
  input  logic       out_ep_acked,
  // IN endpoint (device -> host)
  output logic       in_ep_req,
  input  logic       in_ep_grant,
  input  logic       in_ep_data_free,
  output logic       in_ep_data_put,
  output logic [7:0] in_ep_data,
  output logic       in_ep_data_done,
  output logic       in_ep_stall,
  input  logic       in_ep_acked,
  // frame marker
  input  logic       sof_valid,
  // UART side
  input  logic [7:0] uart_in_data,
  input  logic       uart_in_valid,
  output logic       uart_in_ready,
  output logic [7:0] uart_out_data,
  output logic       uart_out_valid,
  input  logic       uart_out_ready,
  // status
  output logic       host_present,
  output logic [3:0] debug
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int ICW = IAW + 1;
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int OCW = OAW + 1;
  localparam int TW  = $clog2(FLUSH_CYCLES + 1);
  localparam int PW  = $clog2(PRESENCE_CYCLES + 2);

  localparam logic [ICW-1:0] IN_MAX_C    = ICW'(MAX_PKT);
  localparam logic [ICW-1:0] IN_FULL_C   = ICW'(IN_DEPTH);
  localparam logic [OCW-1:0] OUT_MAX_C   = OCW'(MAX_PKT);
  localparam logic [OCW-1:0] OUT_FULL_C  = OCW'(OUT_DEPTH);
  localparam logic [TW-1:0]  FLUSH_C     = TW'(FLUSH_CYCLES);
  localparam logic [PW-1:0]  PRES_C      = PW'(PRESENCE_CYCLES);
  localparam logic [PW-1:0]  PRES_SAT_C  = PW'(PRESENCE_CYCLES + 1);

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_REQ  = 2'd1,
    I_SEND = 2'd2,
    I_ACK  = 2'd3
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_REQ  = 2'd1,
    O_GET  = 2'd2
  } out_state_t;

  // ---------------------------------------------------------------- presence
  logic [PW-1:0] pres_cnt_r;
  logic          host_present_r;

  // SOF watchdog: any SOF marks the host present, a long silence marks it absent
  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      pres_cnt_r     <= '0;
      host_present_r <= 1'b0;
    end else if (sof_valid) begin
      pres_cnt_r     <= '0;
      host_present_r <= 1'b1;
    end else begin
      if (pres_cnt_r != PRES_SAT_C) begin
        pres_cnt_r <= pres_cnt_r + PW'(1);
      end
      if (pres_cnt_r >= PRES_C) begin
        host_present_r <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- IN FIFO
  logic [7:0]     in_mem [IN_DEPTH];
  logic [IAW-1:0] in_wr_r;
  logic [IAW-1:0] in_rd_r;
  logic [ICW-1:0] in_count_r;
  logic [TW-1:0]  in_timer_r;
  in_state_t      in_state_r;
  logic [ICW-1:0] in_rem_r;
  logic [ICW-1:0] in_pkt_len_r;
  logic           in_req_r;
  logic           in_put_r;
  logic           in_done_r;
  logic [7:0]     in_data_r;

  logic           in_full_s;
  logic           in_push_s;
  logic           in_pop_s;
  logic           in_timer_exp_s;
  logic           in_done_evt_s;
  logic           in_grant_evt_s;
  logic           in_start_s;
  logic           zlp_go_s;
  logic [ICW-1:0] in_len_s;

  assign in_full_s      = (in_count_r == IN_FULL_C);
  // ready depends only on registered state, so a full FIFO refuses a push
  // even when a pop happens in the same cycle
  assign uart_in_ready  = !in_full_s || !host_present_r;
  assign in_push_s      = uart_in_valid && uart_in_ready && host_present_r;
  assign in_pop_s       = (in_state_r == I_SEND) && (in_rem_r != '0) && host_present_r;
  assign in_timer_exp_s = (in_timer_r == FLUSH_C);
  assign in_done_evt_s  = (in_state_r == I_ACK) && in_ep_acked && host_present_r;
  assign in_grant_evt_s = (in_state_r == I_REQ) && in_ep_grant && in_ep_data_free;
  assign in_len_s       = (in_count_r >= IN_MAX_C) ? IN_MAX_C : in_count_r;
  assign in_start_s     = host_present_r &&
                          ((in_count_r >= IN_MAX_C) ||
                           ((in_count_r != '0) && in_timer_exp_s) ||
                           zlp_go_s);

  // IN FIFO storage write port
  always_ff @(posedge clk_48mhz) begin
    if (in_push_s) begin
      in_mem[in_wr_r] <= uart_in_data;
    end
  end

  // IN FIFO pointers and occupancy; emptied while no host is present
  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      in_wr_r    <= '0;
      in_rd_r    <= '0;
      in_count_r <= '0;
    end else if (!host_present_r) begin
      in_wr_r    <= '0;
      in_rd_r    <= '0;
      in_count_r <= '0;
    end else begin
      if (in_push_s) begin
        in_wr_r <= in_wr_r + IAW'(1);
      end
      if (in_pop_s) begin
        in_rd_r <= in_rd_r + IAW'(1);
      end
      case ({in_push_s, in_pop_s})
        2'b10:   in_count_r <= in_count_r + ICW'(1);
        2'b01:   in_count_r <= in_count_r - ICW'(1);
        default: in_count_r <= in_count_r;
      endcase
    end
  end

  // idle-flush timer: restarts on new data or finished packet, saturates
  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      in_timer_r <= '0;
    end else if (in_push_s || in_done_evt_s) begin
      in_timer_r <= '0;
    end else if (!in_timer_exp_s) begin
      in_timer_r <= in_timer_r + TW'(1);
    end
  end

`ifdef USB_UART_ZLP_EN
  logic zlp_pend_r;

  // remembers that the last packet was full-size and still needs a terminator
  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      zlp_pend_r <= 1'b0;
    end else if (!host_present_r || in_push_s) begin
      zlp_pend_r <= 1'b0;
    end else if (in_done_evt_s) begin
      zlp_pend_r <= (in_pkt_len_r == IN_MAX_C);
    end else if (in_grant_evt_s) begin
      zlp_pend_r <= 1'b0;
    end
  end

  assign zlp_go_s = zlp_pend_r && (in_count_r == '0) && in_timer_exp_s;
`else
  logic unused_zlp_s;
  assign zlp_go_s     = 1'b0;
  assign unused_zlp_s = ^in_pkt_len_r;
`endif

  // IN packetiser: request, stream len bytes, pulse done, wait for ack
  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      in_state_r   <= I_IDLE;
      in_req_r     <= 1'b0;
      in_put_r     <= 1'b0;
      in_done_r    <= 1'b0;
      in_data_r    <= 8'h00;
      in_rem_r     <= '0;
      in_pkt_len_r <= '0;
    end else if (!host_present_r) begin
      in_state_r <= I_IDLE;
      in_req_r   <= 1'b0;
      in_put_r   <= 1'b0;
      in_done_r  <= 1'b0;
      in_rem_r   <= '0;
    end else begin
      case (in_state_r)
        I_IDLE: begin
          in_put_r  <= 1'b0;
          in_done_r <= 1'b0;
          if (in_start_s) begin
            in_state_r <= I_REQ;
            in_req_r   <= 1'b1;
          end
        end
        I_REQ: begin
          if (in_grant_evt_s) begin
            in_state_r   <= I_SEND;
            in_rem_r     <= in_len_s;
            in_pkt_len_r <= in_len_s;
          end
        end
        I_SEND: begin
          if (in_rem_r != '0) begin
            in_put_r  <= 1'b1;
            in_data_r <= in_mem[in_rd_r];
            in_rem_r  <= in_rem_r - ICW'(1);
          end else begin
            in_put_r   <= 1'b0;
            in_done_r  <= 1'b1;
            in_state_r <= I_ACK;
          end
        end
        I_ACK: begin
          in_done_r <= 1'b0;
          if (in_ep_acked) begin
            in_state_r <= I_IDLE;
            in_req_r   <= 1'b0;
          end
        end
        default: begin
          in_state_r <= I_IDLE;
          in_req_r   <= 1'b0;
          in_put_r   <= 1'b0;
          in_done_r  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- OUT path
  logic [7:0]     out_mem [OUT_DEPTH];
  logic [OAW-1:0] out_wr_r;
  logic [OAW-1:0] out_rd_r;
  logic [OCW-1:0] out_count_r;
  out_state_t     out_state_r;
  logic           out_req_r;
  logic           out_get_d_r;
  logic           out_valid_r;
  logic [7:0]     out_data_r;

  logic [OCW-1:0] out_free_s;
  logic           out_push_s;
  logic           out_load_s;

  assign out_free_s      = OUT_FULL_C - out_count_r;
  assign out_ep_data_get = (out_state_r == O_GET) && out_ep_data_avail;
  assign out_push_s      = out_get_d_r && (out_count_r != OUT_FULL_C);
  assign out_load_s      = (out_count_r != '0) && (!out_valid_r || uart_out_ready);

  // OUT endpoint FSM: request only when a whole packet is guaranteed to fit
  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      out_state_r <= O_IDLE;
      out_req_r   <= 1'b0;
    end else begin
      case (out_state_r)
        O_IDLE: begin
          if (out_ep_data_avail && (out_free_s >= OUT_MAX_C)) begin
            out_state_r <= O_REQ;
            out_req_r   <= 1'b1;
          end
        end
        O_REQ: begin
          if (out_ep_grant) begin
            out_state_r <= O_GET;
          end
        end
        O_GET: begin
          if (!out_ep_data_avail) begin
            out_state_r <= O_IDLE;
            out_req_r   <= 1'b0;
          end
        end
        default: begin
          out_state_r <= O_IDLE;
          out_req_r   <= 1'b0;
        end
      endcase
    end
  end

  // the PE presents each byte the cycle after data_get; track that delay
  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      out_get_d_r <= 1'b0;
    end else begin
      out_get_d_r <= out_ep_data_get;
    end
  end

  // OUT FIFO storage write port
  always_ff @(posedge clk_48mhz) begin
    if (out_push_s) begin
      out_mem[out_wr_r] <= out_ep_data;
    end
  end

  // OUT FIFO pointers and occupancy (output register excluded)
  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      out_wr_r    <= '0;
      out_rd_r    <= '0;
      out_count_r <= '0;
    end else begin
      if (out_push_s) begin
        out_wr_r <= out_wr_r + OAW'(1);
      end
      if (out_load_s) begin
        out_rd_r <= out_rd_r + OAW'(1);
      end
      case ({out_push_s, out_load_s})
        2'b10:   out_count_r <= out_count_r + OCW'(1);
        2'b01:   out_count_r <= out_count_r - OCW'(1);
        default: out_count_r <= out_count_r;
      endcase
    end
  end

  // registered UART output stage, refilled whenever empty or consumed
  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
    end else if (out_load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= out_mem[out_rd_r];
    end else if (out_valid_r && uart_out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- outputs
  logic [1:0] in_state_bits_s;
  logic       unused_s;

  assign in_state_bits_s = in_state_r;
  assign unused_s        = out_ep_setup ^ out_ep_acked;

  assign out_ep_req      = out_req_r;
  assign out_ep_stall    = 1'b0;
  assign in_ep_req       = in_req_r;
  assign in_ep_data_put  = in_put_r;
  assign in_ep_data      = in_data_r;
  assign in_ep_data_done = in_done_r;
  assign in_ep_stall     = 1'b0;
  assign uart_out_valid  = out_valid_r;
  assign uart_out_data   = out_data_r;
  assign host_present    = host_present_r;
  assign debug           = {in_state_bits_s,
                            (in_count_r == '0),
                            ((out_count_r == '0) && !out_valid_r)};

endmodule

// File: tb/tb_usb_uart_fifo_bridge_ep.sv
// Directed testbench for usb_uart_fifo_bridge_ep with shortened timers
// (FLUSH_CYCLES=100, PRESENCE_CYCLES=400), MAX_PKT=32, 64-byte FIFOs.
module tb_usb_uart_fifo_bridge_ep;
  localparam int FLUSH = 100;
  localparam int PRES  = 400;

  logic       clk_48mhz = 1'b0;
  logic       reset;
  logic       out_ep_req, out_ep_grant, out_ep_data_avail, out_ep_setup;
  logic       out_ep_data_get, out_ep_stall, out_ep_acked;
  logic [7:0] out_ep_data;
  logic       in_ep_req, in_ep_grant, in_ep_data_free, in_ep_data_put;
  logic [7:0] in_ep_data;
  logic       in_ep_data_done, in_ep_stall, in_ep_acked;
  logic       sof_valid;
  logic [7:0] uart_in_data;
  logic       uart_in_valid, uart_in_ready;
  logic [7:0] uart_out_data;
  logic       uart_out_valid, uart_out_ready;
  logic       host_present;
  logic [3:0] debug;

  int         n_cmp = 0;
  int         n_bad = 0;
  bit         sof_auto = 1'b0;
  logic [7:0] cap_buf [64];
  logic [7:0] rx_buf [128];
  int         rx_n;

  usb_uart_fifo_bridge_ep #(
    .IN_DEPTH(64), .OUT_DEPTH(64), .MAX_PKT(32),
    .FLUSH_CYCLES(FLUSH), .PRESENCE_CYCLES(PRES)
  ) dut (
    .clk_48mhz(clk_48mhz), .reset(reset),
    .out_ep_req(out_ep_req), .out_ep_grant(out_ep_grant),
    .out_ep_data_avail(out_ep_data_avail), .out_ep_setup(out_ep_setup),
    .out_ep_data_get(out_ep_data_get), .out_ep_data(out_ep_data),
    .out_ep_stall(out_ep_stall), .out_ep_acked(out_ep_acked),
    .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant),
    .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put),
    .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
    .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
    .sof_valid(sof_valid),
    .uart_in_data(uart_in_data), .uart_in_valid(uart_in_valid),
    .uart_in_ready(uart_in_ready),
    .uart_out_data(uart_out_data), .uart_out_valid(uart_out_valid),
    .uart_out_ready(uart_out_ready),
    .host_present(host_present), .debug(debug)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SOF generator: one pulse every 50 cycles while enabled
  initial begin
    sof_valid = 1'b0;
    for (int k = 0; ; k++) begin
      @(posedge clk_48mhz); #1;
      sof_valid = sof_auto && (k % 50 == 0);
    end
  end

  task automatic tick();
    @(posedge clk_48mhz); #1;
  endtask

  task automatic push_bytes(input int n, input int base, output int not_ready);
    not_ready = 0;
    for (int i = 0; i < n; i++) begin
      uart_in_data  = 8'(base + i);
      uart_in_valid = 1'b1;
      @(negedge clk_48mhz);
      if (!uart_in_ready) not_ready++;
      @(posedge clk_48mhz); #1;
    end
    uart_in_valid = 1'b0;
  endtask

  // IN host model: grant, collect puts until data_done, then ack
  task automatic in_host(output int n_put, output int n_done, output bit tmo);
    int cyc;
    n_put = 0; n_done = 0; tmo = 1'b0; cyc = 0;
    in_ep_grant = 1'b1; in_ep_data_free = 1'b1;
    while (n_done == 0 && cyc < 400) begin
      @(negedge clk_48mhz);
      if (in_ep_data_put) begin
        if (n_put < 64) cap_buf[n_put] = in_ep_data;
        n_put++;
      end
      if (in_ep_data_done) n_done++;
      @(posedge clk_48mhz); #1;
      cyc++;
    end
    if (n_done == 0) tmo = 1'b1;
    in_ep_acked = 1'b1;
    tick();
    in_ep_acked = 1'b0;
    in_ep_grant = 1'b0;
  endtask

  // OUT PE model plus optional UART drain with ready toggling every cycle
  task automatic out_session(input int n, input int base, input bit drain,
                             input int expect_rx, output bit tmo);
    int idx, cyc;
    logic g, r;
    idx = 0; cyc = 0; tmo = 1'b0;
    out_ep_data_avail = (n > 0);
    while ((out_ep_data_avail || rx_n < expect_rx) && cyc < 400) begin
      @(negedge clk_48mhz);
      g = out_ep_data_get;
      r = out_ep_req;
      if (uart_out_valid && uart_out_ready && rx_n < 128) begin
        rx_buf[rx_n] = uart_out_data;
        rx_n++;
      end
      @(posedge clk_48mhz); #1;
      out_ep_grant = r;
      if (g) begin
        out_ep_data = 8'(base + idx);
        idx++;
        if (idx >= n) out_ep_data_avail = 1'b0;
      end
      if (drain) uart_out_ready = ~uart_out_ready;
      cyc++;
    end
    if (cyc >= 400) tmo = 1'b1;
    out_ep_grant = 1'b0;
    uart_out_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    @(negedge clk_48mhz);
    n_cmp++; if (out_ep_req !== 1'b0) begin n_bad++; $display("FAIL rst_out_req: got %b want 0", out_ep_req); end
    n_cmp++; if (out_ep_data_get !== 1'b0) begin n_bad++; $display("FAIL rst_out_get: got %b want 0", out_ep_data_get); end
    n_cmp++; if (in_ep_req !== 1'b0) begin n_bad++; $display("FAIL rst_in_req: got %b want 0", in_ep_req); end
    n_cmp++; if (in_ep_data_put !== 1'b0) begin n_bad++; $display("FAIL rst_in_put: got %b want 0", in_ep_data_put); end
    n_cmp++; if (in_ep_data_done !== 1'b0) begin n_bad++; $display("FAIL rst_in_done: got %b want 0", in_ep_data_done); end
    n_cmp++; if ({out_ep_stall, in_ep_stall} !== 2'b00) begin n_bad++; $display("FAIL rst_stall: got %b want 00", {out_ep_stall, in_ep_stall}); end
    n_cmp++; if (uart_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_uart_out_valid: got %b want 0", uart_out_valid); end
    n_cmp++; if (uart_in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_uart_in_ready: got %b want 1", uart_in_ready); end
    n_cmp++; if (host_present !== 1'b0) begin n_bad++; $display("FAIL rst_host_present: got %b want 0", host_present); end
    n_cmp++; if (debug !== 4'b0011) begin n_bad++; $display("FAIL rst_debug: got %b want 0011", debug); end
    @(posedge clk_48mhz); #1;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_presence_on();
    int cyc;
    sof_auto = 1'b1;
    cyc = 0;
    while (!host_present && cyc < 100) begin tick(); cyc++; end
    n_cmp++; if (host_present !== 1'b1) begin n_bad++; $display("FAIL presence_on: got %b want 1", host_present); end
  endtask

  task automatic test_full_packet();
    int nr, np, nd, bad_bytes, req_seen;
    bit tmo;
    push_bytes(32, 8'h10, nr);
    n_cmp++; if (nr !== 0) begin n_bad++; $display("FAIL full_push_ready: got %0d stalls want 0", nr); end
    @(negedge clk_48mhz);
    n_cmp++; if (in_ep_req !== 1'b0) begin n_bad++; $display("FAIL full_req_early: got %b want 0", in_ep_req); end
    tick();
    @(negedge clk_48mhz);
    n_cmp++; if (in_ep_req !== 1'b1) begin n_bad++; $display("FAIL full_req_rise: got %b want 1", in_ep_req); end
    in_host(np, nd, tmo);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL full_timeout: got %b want 0", tmo); end
    n_cmp++; if (np !== 32) begin n_bad++; $display("FAIL full_puts: got %0d want 32", np); end
    n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL full_done: got %0d want 1", nd); end
    bad_bytes = 0;
    for (int i = 0; i < 32; i++) if (cap_buf[i] !== 8'(8'h10 + i)) bad_bytes++;
    n_cmp++; if (bad_bytes !== 0) begin n_bad++; $display("FAIL full_bytes: got %0d wrong bytes want 0", bad_bytes); end
    @(negedge clk_48mhz);
    n_cmp++; if (in_ep_req !== 1'b0) begin n_bad++; $display("FAIL full_req_after_ack: got %b want 0", in_ep_req); end
    n_cmp++; if (debug[1] !== 1'b1) begin n_bad++; $display("FAIL full_in_empty: got %b want 1", debug[1]); end
`ifdef USB_UART_ZLP_EN
    in_host(np, nd, tmo);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL zlp_timeout: got %b want 0", tmo); end
    n_cmp++; if (np !== 0) begin n_bad++; $display("FAIL zlp_puts: got %0d want 0", np); end
    n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL zlp_done: got %0d want 1", nd); end
`endif
    req_seen = 0;
    for (int i = 0; i < 3 * FLUSH; i++) begin
      @(negedge clk_48mhz);
      if (in_ep_req) req_seen++;
      tick();
    end
    n_cmp++; if (req_seen !== 0) begin n_bad++; $display("FAIL no_extra_packet: got %0d req cycles want 0", req_seen); end
  endtask

  task automatic test_short_packet();
    int nr, np, nd, cyc, bad_bytes;
    bit tmo;
    push_bytes(5, 8'hA0, nr);
    cyc = 0;
    do begin tick(); cyc++; end while (!in_ep_req && cyc < 400);
    n_cmp++; if (cyc < FLUSH || cyc > FLUSH + 2) begin n_bad++; $display("FAIL short_latency: got %0d cycles want %0d+-1", cyc, FLUSH + 1); end
    in_host(np, nd, tmo);
    n_cmp++; if (np !== 5 || nd !== 1 || tmo !== 1'b0) begin n_bad++; $display("FAIL short_packet: got puts=%0d done=%0d tmo=%b want 5 1 0", np, nd, tmo); end
    bad_bytes = 0;
    for (int i = 0; i < 5; i++) if (cap_buf[i] !== 8'(8'hA0 + i)) bad_bytes++;
    n_cmp++; if (bad_bytes !== 0) begin n_bad++; $display("FAIL short_bytes: got %0d wrong bytes want 0", bad_bytes); end
  endtask

  task automatic test_out_flow();
    bit tmo1, tmo2, tmo3;
    int req_seen, bad_bytes;
    rx_n = 0;
    uart_out_ready = 1'b0;
    out_session(32, 8'h00, 1'b0, 0, tmo1);
    out_session(32, 8'h20, 1'b0, 0, tmo2);
    n_cmp++; if ({tmo1, tmo2} !== 2'b00) begin n_bad++; $display("FAIL out_fill_timeout: got %b want 00", {tmo1, tmo2}); end
    out_ep_data_avail = 1'b1;
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_48mhz);
      if (out_ep_req) req_seen++;
      tick();
    end
    out_ep_data_avail = 1'b0;
    n_cmp++; if (req_seen !== 0) begin n_bad++; $display("FAIL out_req_while_full: got %0d req cycles want 0", req_seen); end
    out_session(0, 0, 1'b1, 64, tmo3);
    n_cmp++; if (rx_n !== 64 || tmo3 !== 1'b0) begin n_bad++; $display("FAIL out_drain_count: got %0d tmo=%b want 64 0", rx_n, tmo3); end
    bad_bytes = 0;
    for (int i = 0; i < 64; i++) if (rx_buf[i] !== 8'(i)) bad_bytes++;
    n_cmp++; if (bad_bytes !== 0) begin n_bad++; $display("FAIL out_drain_order: got %0d wrong bytes want 0", bad_bytes); end
  endtask

  task automatic test_out_toggle();
    bit tmo;
    int bad_bytes;
    rx_n = 0;
    out_session(20, 8'h80, 1'b1, 20, tmo);
    n_cmp++; if (rx_n !== 20 || tmo !== 1'b0) begin n_bad++; $display("FAIL out_toggle_count: got %0d tmo=%b want 20 0", rx_n, tmo); end
    bad_bytes = 0;
    for (int i = 0; i < 20; i++) if (rx_buf[i] !== 8'(8'h80 + i)) bad_bytes++;
    n_cmp++; if (bad_bytes !== 0) begin n_bad++; $display("FAIL out_toggle_order: got %0d wrong bytes want 0", bad_bytes); end
    @(negedge clk_48mhz);
    n_cmp++; if (debug[0] !== 1'b1) begin n_bad++; $display("FAIL out_empty_after: got %b want 1", debug[0]); end
  endtask

  task automatic test_presence_loss();
    int nr, req_seen;
    sof_auto = 1'b0;
    push_bytes(3, 8'h55, nr);
    repeat (PRES + 70) tick();
    @(negedge clk_48mhz);
    n_cmp++; if (host_present !== 1'b0) begin n_bad++; $display("FAIL loss_host_present: got %b want 0", host_present); end
    n_cmp++; if (in_ep_req !== 1'b0) begin n_bad++; $display("FAIL loss_req: got %b want 0", in_ep_req); end
    n_cmp++; if (debug[1] !== 1'b1) begin n_bad++; $display("FAIL loss_fifo_cleared: got %b want 1", debug[1]); end
    n_cmp++; if (uart_in_ready !== 1'b1) begin n_bad++; $display("FAIL loss_ready: got %b want 1", uart_in_ready); end
    tick();
    push_bytes(70, 8'h00, nr);
    n_cmp++; if (nr !== 0) begin n_bad++; $display("FAIL absent_ready: got %0d stalls want 0", nr); end
    req_seen = 0;
    for (int i = 0; i < FLUSH + 50; i++) begin
      @(negedge clk_48mhz);
      if (in_ep_req) req_seen++;
      tick();
    end
    n_cmp++; if (req_seen !== 0 || debug[1] !== 1'b1) begin n_bad++; $display("FAIL absent_discard: got req=%0d empty=%b want 0 1", req_seen, debug[1]); end
  endtask

  task automatic test_reset_mid_send();
    int nr, cyc;
    sof_auto = 1'b1;
    cyc = 0;
    while (!host_present && cyc < 100) begin tick(); cyc++; end
    push_bytes(32, 8'h00, nr);
    in_ep_grant = 1'b1; in_ep_data_free = 1'b1;
    cyc = 0;
    while (!in_ep_data_put && cyc < 50) begin tick(); cyc++; end
    n_cmp++; if (in_ep_data_put !== 1'b1) begin n_bad++; $display("FAIL mid_send_start: got %b want 1", in_ep_data_put); end
    tick(); tick();
    reset = 1'b0;
    tick();
    @(negedge clk_48mhz);
    n_cmp++; if (in_ep_data_put !== 1'b0 || in_ep_data_done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_put_done: got %b%b want 00", in_ep_data_put, in_ep_data_done); end
    n_cmp++; if (in_ep_req !== 1'b0 || out_ep_req !== 1'b0) begin n_bad++; $display("FAIL mid_rst_req: got %b%b want 00", in_ep_req, out_ep_req); end
    n_cmp++; if (host_present !== 1'b0) begin n_bad++; $display("FAIL mid_rst_host: got %b want 0", host_present); end
    n_cmp++; if (debug !== 4'b0011) begin n_bad++; $display("FAIL mid_rst_debug: got %b want 0011", debug); end
    n_cmp++; if (uart_in_ready !== 1'b1 || uart_out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_uart: got rdy=%b vld=%b want 1 0", uart_in_ready, uart_out_valid); end
    tick();
    reset = 1'b1;
    in_ep_grant = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    out_ep_grant = 1'b0; out_ep_data_avail = 1'b0; out_ep_setup = 1'b0;
    out_ep_data = 8'h00; out_ep_acked = 1'b0;
    in_ep_grant = 1'b0; in_ep_data_free = 1'b0; in_ep_acked = 1'b0;
    uart_in_data = 8'h00; uart_in_valid = 1'b0; uart_out_ready = 1'b0;
    rx_n = 0;
    test_reset();
    test_presence_on();
    test_full_packet();
    test_short_packet();
    test_out_flow();
    test_out_toggle();
    test_presence_loss();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/usb_uart_fifo_bridge_ep.md
# usb_uart_fifo_bridge_ep

Parametrised CDC data-endpoint bridge between the USB full-speed protocol engine (one OUT and one IN endpoint slot) and a byte-wide valid/ready UART pipeline. Adds sized IN/OUT FIFOs, configurable max packet size, an idle-flush timer for short IN packets, and SOF-based host-presence tracking that discards device-to-host traffic when no host is present. Instantiated in place of the fixed bridge endpoint under the usb_uart top, fed by the same shared `out_ep_data` bus and `sof_valid`.

## Interface
- IN_DEPTH, 64, IN FIFO bytes; power of 2, ≥ MAX_PKT
- OUT_DEPTH, 64, OUT FIFO bytes; power of 2, ≥ MAX_PKT
- MAX_PKT, 32, bulk max packet size in bytes (8..64)
- FLUSH_CYCLES, 48000, idle cycles before a short IN packet is sent (1 ms)
- PRESENCE_CYCLES, 48000000, cycles without SOF before host declared absent
- clk_48mhz in 1 — single clock, all logic on rising edge
- reset in 1 — synchronous, active-low: sampled low on a clock edge resets all state
- out_ep_req / out_ep_grant / out_ep_data_avail / out_ep_setup / out_ep_data_get / out_ep_data[7:0] / out_ep_stall / out_ep_acked — OUT endpoint port, directions as in the PE (req, data_get, stall outputs; rest inputs)
- in_ep_req / in_ep_grant / in_ep_data_free / in_ep_data_put / in_ep_data[7:0] / in_ep_data_done / in_ep_stall / in_ep_acked — IN endpoint port (req, data_put, data, data_done, stall outputs; rest inputs)
- sof_valid in 1 — SOF received pulse
- uart_in_data in 8, uart_in_valid in 1, uart_in_ready out 1 — device→host bytes
- uart_out_data out 8, uart_out_valid out 1, uart_out_ready in 1 — host→device bytes
- host_present out 1 — SOF seen within PRESENCE_CYCLES
- debug out 4 — {in_state[1:0], in_empty, out_empty}

## Operation
- Stalls: out_ep_stall = in_ep_stall = 0 always; out_ep_setup ignored.
- OUT path FSM: O_IDLE → O_REQ when out_ep_data_avail and OUT free ≥ MAX_PKT (out_ep_req=1). O_REQ → O_GET on out_ep_grant: out_ep_data_get=1 while data_avail; byte on out_ep_data written to FIFO the cycle after each data_get. O_GET → O_IDLE when data_avail falls; req drops same cycle; trailing in-flight byte still written.
- OUT FIFO drains to uart_out_*: pop on uart_out_valid & uart_out_ready.
- IN FIFO push on uart_in_valid & uart_in_ready; uart_in_ready = !in_full, or 1 when host_present=0 (byte accepted and discarded; FIFO also cleared on host_present falling).
- Idle timer: reset on every IN push or packet completion; counts to FLUSH_CYCLES, saturates.
- IN FSM: I_IDLE → I_REQ when host_present and (in_count ≥ MAX_PKT or (in_count>0 and timer expired)). I_REQ (in_ep_req=1) → I_SEND on in_ep_grant & in_ep_data_free; snapshot len = min(in_count, MAX_PKT). I_SEND: in_ep_data_put=1 one byte per cycle, popping FIFO, len cycles; then in_ep_data_done pulse 1 cycle → I_ACK. I_ACK: req held until in_ep_acked → I_IDLE, req low next cycle. Grant loss in I_REQ holds I_REQ.
- Host presence: counter cleared by sof_valid, +1 otherwise, saturating; host_present = counter ≤ PRESENCE_CYCLES. Host absent in I_REQ/I_ACK → I_IDLE, req dropped.
- Simultaneous IN push and pop: count unchanged; full FIFO with simultaneous pop still refuses push (ready from registered state).

## Timing
- Reset values: all req/get/put/done/stall 0, uart_out_valid 0, uart_in_ready 1, host_present 0, FIFOs empty, FSMs idle, counters 0.
- uart_in byte to in_count visible: 1 cycle. OUT byte capture to uart_out_valid: 1 cycle (registered FIFO output).
- Full packet: I_IDLE → I_REQ 1 cycle after count reaches MAX_PKT; data_done 1 cycle after last put.
- Short packet: sent FLUSH_CYCLES+1 cycles after last push (±1).
- Pointers wrap modulo depth; count width clog2(depth)+1.
- Reset mid-transfer: next cycle all outputs at reset values, partial packet lost.

## Configuration
- USB_UART_ZLP_EN defined: after a MAX_PKT-length IN packet acked with FIFO empty and timer expired, send a zero-length packet (I_REQ → I_SEND with len 0 → data_done immediately). Undefined: no ZLPs; exact-multiple transfers end without terminator.

## Test plan
- Reset low 2 cycles mid I_SEND → all outputs reset values, in_count 0, host_present 0.
- 10 SOFs then 32 bytes pushed (MAX_PKT=32) → in_ep_req, 32 data_puts, one data_done; after acked req low, in_count 0.
- 5 bytes pushed, no more → packet of 5 sent ≈48001 cycles after last push.
- OUT packet of 20 bytes, uart_out_ready toggled 50% → 20 bytes delivered in order; req only when free ≥ 32.
- No SOF for PRESENCE_CYCLES+1 → host_present 0, IN FIFO cleared, uart_in_ready 1, no in_ep_req.
- USB_UART_ZLP_EN, 32 bytes then idle → 32-byte packet then 0-byte packet (data_done, no puts); without macro only one.
